// File: rtl/brush_stamp_writer.sv
// brush_stamp_writer
//   Converts cursor positions into square brush stamps on the frame buffer.
//   While paint_en is held and the cursor has moved (or painting has just
//   started), the block scans a (2r+1)x(2r+1) square centred on the cursor in
//   row-major order. Each on-screen pixel becomes one write on a req/ack port.
//   Off-screen pixels are skipped at one cycle each.
//
// Ports
//   clk_clk, reset_reset        clock, synchronous active-high reset
//   cursor_x/y, paint_en        cursor position and paint button
//   brush_radius, brush_color   brush half-size (clamped to MAX_RADIUS), colour
//   fb_req/addr/data, fb_ack    single-pixel frame-buffer write handshake
//   busy                        stamp in progress (SCAN/WAIT/DONE)
//   stamp_done                  one-cycle pulse as a stamp finishes
module brush_stamp_writer #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int MAX_RADIUS = 7,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [15:0]        cursor_x,
  input  logic [15:0]        cursor_y,
  input  logic               paint_en,
  input  logic [2:0]         brush_radius,
  input  logic [COLOR_W-1:0] brush_color,
  output logic               fb_req,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ack,
  output logic               busy,
  output logic               stamp_done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cx_q, cx_d, cy_q, cy_d;
  logic [15:0]         last_x_q, last_x_d, last_y_q, last_y_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic [2:0]          r_q, r_d;
  logic signed [3:0]   dx_q, dx_d, dy_q, dy_d;
  logic                first_q, first_d;
  logic                fb_req_q, fb_req_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0]  fb_data_q, fb_data_d;

  // Pixel under the scan, 17-bit signed so that cx+dx can go below zero.
  logic signed [16:0]  px, py;
  logic signed [3:0]   r_s;
  logic                on_screen, last_pix, trigger;
  logic [2:0]          r_in;
  logic signed [3:0]   dx_adv, dy_adv;
  logic [ADDR_W-1:0]   px_a, py_a, pix_addr;

  assign r_s = $signed({1'b0, r_q});
  assign px  = $signed({1'b0, cx_q}) + $signed({{13{dx_q[3]}}, dx_q});
  assign py  = $signed({1'b0, cy_q}) + $signed({{13{dy_q[3]}}, dy_q});

  // Sign bit clear means non-negative; then the low 16 bits are the value.
  assign on_screen = !px[16] && (px[15:0] < 16'(SCREEN_W)) &&
                     !py[16] && (py[15:0] < 16'(SCREEN_H));

  assign px_a     = ADDR_W'(px[15:0]);
  assign py_a     = ADDR_W'(py[15:0]);
  assign pix_addr = py_a * ADDR_W'(SCREEN_W) + px_a;

  assign last_pix = (dx_q == r_s) && (dy_q == r_s);

  // Row-major step: dx wraps to -r and bumps dy at the end of each row.
  assign dx_adv = (dx_q == r_s) ? -r_s : dx_q + 4'sd1;
  assign dy_adv = (dx_q == r_s) ? dy_q + 4'sd1 : dy_q;

  assign r_in    = (brush_radius > 3'(MAX_RADIUS)) ? 3'(MAX_RADIUS) : brush_radius;
  assign trigger = paint_en &&
                   (first_q || (cursor_x != last_x_q) || (cursor_y != last_y_q));

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    last_x_d  = last_x_q;
    last_y_d  = last_y_q;
    color_d   = color_q;
    r_d       = r_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    first_d   = first_q;
    fb_req_d  = fb_req_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (!paint_en) first_d = 1'b1;
        if (trigger) begin
          cx_d    = cursor_x;
          cy_d    = cursor_y;
          color_d = brush_color;
          r_d     = r_in;
          dx_d    = -$signed({1'b0, r_in});
          dy_d    = -$signed({1'b0, r_in});
          first_d = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (on_screen) begin
          fb_req_d  = 1'b1;
          fb_addr_d = pix_addr;
          fb_data_d = color_q;
          state_d   = S_WAIT;
        end else begin
          dx_d    = dx_adv;
          dy_d    = dy_adv;
          state_d = last_pix ? S_DONE : S_SCAN;
        end
      end
      S_WAIT: begin
        if (fb_ack) begin
          fb_req_d = 1'b0;
          dx_d     = dx_adv;
          dy_d     = dy_adv;
          state_d  = last_pix ? S_DONE : S_SCAN;
        end
      end
      S_DONE: begin
        last_x_d = cx_q;
        last_y_d = cy_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= S_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      last_x_q  <= '0;
      last_y_q  <= '0;
      color_q   <= '0;
      r_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      first_q   <= 1'b1;
      fb_req_q  <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      last_x_q  <= last_x_d;
      last_y_q  <= last_y_d;
      color_q   <= color_d;
      r_q       <= r_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      first_q   <= first_d;
      fb_req_q  <= fb_req_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign fb_req     = fb_req_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign busy       = (state_q != S_IDLE);
  assign stamp_done = (state_q == S_DONE);

endmodule

// File: tb/tb_brush_stamp_writer.sv
module tb_brush_stamp_writer;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int AW = 19;
  localparam int CW = 16;

  logic          clk_clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic [15:0]   cursor_x = '0, cursor_y = '0;
  logic          paint_en = 1'b0;
  logic [2:0]    brush_radius = '0;
  logic [CW-1:0] brush_color = '0;
  logic          fb_req;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_data;
  logic          fb_ack = 1'b0;
  logic          busy, stamp_done;

  brush_stamp_writer dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .paint_en(paint_en),
    .brush_radius(brush_radius), .brush_color(brush_color),
    .fb_req(fb_req), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ack(fb_ack),
    .busy(busy), .stamp_done(stamp_done)
  );

  always #5 clk_clk = ~clk_clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Arbiter model + write monitor, all on the falling edge.
  int            ack_lat = 0, wcnt = 0, done_cnt = 0, unstable = 0;
  int            obs_a[$], obs_d[$];
  logic          prev_req = 1'b0, prev_acc = 1'b0, prev_rst = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [CW-1:0] prev_data = '0;

  always @(negedge clk_clk) begin
    logic acc;
    if (stamp_done) done_cnt++;
    if (!prev_rst && !reset_reset && prev_req && !prev_acc)
      if (!fb_req || fb_addr !== prev_addr || fb_data !== prev_data) unstable++;
    if (reset_reset || !fb_req) begin
      fb_ack = 1'b0; wcnt = 0;
    end else if (wcnt >= ack_lat) begin
      fb_ack = 1'b1; wcnt = 0;
    end else begin
      fb_ack = 1'b0; wcnt++;
    end
    acc = fb_req && fb_ack && !reset_reset;
    if (acc) begin
      obs_a.push_back(int'(fb_addr));
      obs_d.push_back(int'(fb_data));
    end
    prev_req = fb_req; prev_acc = acc; prev_addr = fb_addr;
    prev_data = fb_data; prev_rst = reset_reset;
  end

  // Reference model: what a stamp should write, and when one should fire.
  int exp_a[$];
  int m_last_x = 0, m_last_y = 0;
  bit m_first = 1'b1;

  task automatic build_exp(input int x, input int y, input int r);
    int rr;
    rr = (r > 7) ? 7 : r;
    exp_a.delete();
    for (int dy = -rr; dy <= rr; dy++)
      for (int dx = -rr; dx <= rr; dx++)
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          exp_a.push_back((y + dy) * W + (x + dx));
  endtask

  task automatic run_stamp(input int x, input int y, input int r, input logic [15:0] col,
                           input int lat, input bit scr, output int cyc);
    int d0;
    bit got;
    build_exp(x, y, r);
    obs_a.delete(); obs_d.delete();
    d0 = done_cnt; ack_lat = lat;
    @(negedge clk_clk);
    cursor_x = 16'(x); cursor_y = 16'(y); brush_radius = 3'(r);
    brush_color = col; paint_en = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 4000) begin
      @(negedge clk_clk);
      cyc++;
      if (stamp_done) got = 1'b1;
      else if (scr) begin
        brush_color = 16'($urandom); brush_radius = 3'($urandom);
      end
    end
    chk("stamp_done_seen", 32'(got), 32'd1);
    repeat (3) @(negedge clk_clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("write_count", obs_a.size(), exp_a.size());
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      chk("write_addr", obs_a[i], exp_a[i]);
      chk("write_data", obs_d[i], {16'd0, col});
    end
    m_last_x = x; m_last_y = y; m_first = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, d0, n;
    bit got;

    // reset state
    repeat (3) @(negedge clk_clk);
    chk("rst_fb_req", 32'(fb_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(stamp_done), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    #1 reset_reset = 1'b0;

    // single pixel, exact cycle timing
    obs_a.delete(); obs_d.delete(); ack_lat = 0;
    @(negedge clk_clk);
    cursor_x = 16'd10; cursor_y = 16'd20; brush_radius = 3'd0;
    brush_color = 16'hF800; paint_en = 1'b1;
    @(negedge clk_clk);
    chk("sp_c1_req", 32'(fb_req), 0);
    chk("sp_c1_busy", 32'(busy), 1);
    @(negedge clk_clk);
    chk("sp_c2_req", 32'(fb_req), 1);
    chk("sp_c2_addr", 32'(fb_addr), 12810);
    chk("sp_c2_data", 32'(fb_data), 32'hF800);
    @(negedge clk_clk);
    chk("sp_c3_done", 32'(stamp_done), 1);
    chk("sp_c3_req", 32'(fb_req), 0);
    @(negedge clk_clk);
    chk("sp_c4_busy", 32'(busy), 0);
    chk("sp_writes", obs_a.size(), 1);
    m_last_x = 10; m_last_y = 20; m_first = 1'b0;

    // top-left clip
    run_stamp(0, 0, 1, 16'h07E0, 0, 1'b0, cyc);
    chk("tl_count", obs_a.size(), 4);
    if (obs_a.size() == 4) begin
      chk("tl_a0", obs_a[0], 0);   chk("tl_a1", obs_a[1], 1);
      chk("tl_a2", obs_a[2], 640); chk("tl_a3", obs_a[3], 641);
    end

    // bottom-right clip
    run_stamp(639, 479, 2, 16'h001F, 0, 1'b0, cyc);
    chk("br_count", obs_a.size(), 9);
    if (obs_a.size() > 0) begin
      chk("br_first", obs_a[0], 305917);
      chk("br_last", obs_a[obs_a.size()-1], 307199);
    end

    // ack stall, inputs scrambled mid-stamp
    run_stamp(50, 60, 1, 16'h1234, 3, 1'b1, cyc);

    // stationary vs moving cursor
    run_stamp(100, 100, 2, 16'hABCD, 0, 1'b0, cyc);
    d0 = done_cnt; obs_a.delete();
    repeat (200) @(negedge clk_clk);
    chk("still_no_stamp", done_cnt - d0, 0);
    chk("still_no_write", obs_a.size(), 0);
    run_stamp(101, 100, 2, 16'hABCD, 1, 1'b0, cyc);
    d0 = done_cnt;
    repeat (200) @(negedge clk_clk);
    chk("moved_one_stamp", done_cnt - d0, 0);
    paint_en = 1'b0;
    repeat (5) @(negedge clk_clk);
    m_first = 1'b1;
    run_stamp(101, 100, 1, 16'h5555, 0, 1'b0, cyc);

    // fully off-screen stamp still scans all 49 positions
    run_stamp(65535, 100, 3, 16'hFFFF, 0, 1'b0, cyc);
    chk("offscr_cycles", cyc, 50);

    // reset while waiting on ack
    obs_a.delete(); ack_lat = 20;
    @(negedge clk_clk);
    cursor_x = 16'd300; cursor_y = 16'd200; brush_radius = 3'd2; paint_en = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk_clk); n++;
      if (fb_req) got = 1'b1;
    end
    chk("rw_req_seen", 32'(got), 1);
    #1 reset_reset = 1'b1; paint_en = 1'b0;
    @(negedge clk_clk);
    chk("rw_req_after", 32'(fb_req), 0);
    chk("rw_busy_after", 32'(busy), 0);
    #1 reset_reset = 1'b0;
    m_first = 1'b1; m_last_x = 0; m_last_y = 0;
    repeat (30) @(negedge clk_clk);
    chk("rw_no_writes", obs_a.size(), 0);

    // randomized operations against the model
    for (int k = 0; k < 30; k++) begin
      int op, x, y;
      op = int'($urandom_range(0, 9));
      if (op < 2) begin
        paint_en = 1'b0;
        repeat (3) @(negedge clk_clk);
        m_first = 1'b1;
      end else if (op < 3 && !m_first) begin
        d0 = done_cnt; obs_a.delete();
        cursor_x = 16'(m_last_x); cursor_y = 16'(m_last_y); paint_en = 1'b1;
        repeat (40) @(negedge clk_clk);
        chk("rnd_hold_stamp", done_cnt - d0, 0);
        chk("rnd_hold_write", obs_a.size(), 0);
      end else begin
        x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(65520, 65535))
                                        : int'($urandom_range(0, 660));
        y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(65520, 65535))
                                        : int'($urandom_range(0, 500));
        if (!m_first && x == m_last_x && y == m_last_y) y = (y == 0) ? 1 : y - 1;
        run_stamp(x, y, int'($urandom_range(0, 7)), 16'($urandom),
                  int'($urandom_range(0, 3)), 1'b1, cyc);
      end
    end

    chk("req_stability", unstable, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
